// File: rtl/uart_pkg.sv
// Shared UART types and defaults.
// Used by uart_rx (and the transmitter side of the link).
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for asynchronous inputs.
// Reset value and width are parameters.
module sync_2ff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/uart_rx.sv
// Mid-bit sampling UART receiver with one-entry holding register.
// Optional parity check under UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  input  logic                 err_clr
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [2:0]    LAST = 3'(DATA_BITS - 1);

  logic w_rxs;
  logic r_rxs_d;

  uart_rx_state_e r_state;
  uart_rx_state_e w_state_nxt;

  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [2:0]           r_bitn;
  logic [2:0]           w_bitn_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_zero;
  logic                 w_stop_ok;
  logic                 w_stop_bad;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;

  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_sync (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_d    (rxd),
    .o_q    (w_rxs)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par;
  logic w_par_nxt;
  logic w_par_bad;
  logic r_perr;

  assign w_par_bad  = ((^r_shift) ^ r_par) != PARITY_ODD;
  assign parity_err = r_perr;
`endif

  assign w_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bitn_nxt  = r_bitn;
    w_shift_nxt = r_shift;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    unique case (r_state)
      RX_IDLE: begin
        // Require a real high-to-low edge, not a line held low.
        if (!w_rxs && r_rxs_d) begin
          w_state_nxt = RX_START;
          w_cnt_nxt   = HALF;
        end
      end
      RX_START: begin
        if (!w_zero) begin
          w_cnt_nxt = r_cnt - ONE;
        end else if (w_rxs) begin
          w_state_nxt = RX_IDLE;
        end else begin
          w_state_nxt = RX_DATA;
          w_cnt_nxt   = FULL;
          w_bitn_nxt  = '0;
        end
      end
      RX_DATA: begin
        if (!w_zero) begin
          w_cnt_nxt = r_cnt - ONE;
        end else begin
          w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
          w_cnt_nxt   = FULL;
          w_bitn_nxt  = r_bitn + 3'd1;
          if (r_bitn == LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = RX_PARITY;
`else
            w_state_nxt = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (!w_zero) begin
          w_cnt_nxt = r_cnt - ONE;
        end else begin
          w_par_nxt   = w_rxs;
          w_cnt_nxt   = FULL;
          w_state_nxt = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (!w_zero) begin
          w_cnt_nxt = r_cnt - ONE;
        end else if (w_rxs) begin
          w_stop_ok   = 1'b1;
          w_state_nxt = RX_IDLE;
        end else begin
          w_stop_bad  = 1'b1;
          w_state_nxt = RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (w_rxs) begin
          w_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_rxs_d <= 1'b1;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bitn  <= w_bitn_nxt;
      r_shift <= w_shift_nxt;
      r_rxs_d <= w_rxs;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // A drain in the same cycle frees the slot for the new byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_ferr <= w_stop_bad;
      if (w_stop_ok && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
      if (w_stop_ok && r_valid && !rx_ready) begin
        r_ovr <= 1'b1;
      end else if (err_clr) begin
        r_ovr <= 1'b0;
      end
`ifdef UART_RX_PARITY_EN
      r_perr <= (w_stop_ok | w_stop_bad) & w_par_bad;
`endif
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign frame_err   = r_ferr;
  assign overrun_err = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
// Parity scenario runs when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         pe_cnt = 0;
`endif

  int n_run  = 0;
  int n_fail = 0;
  int fe_cnt = 0;

  uart_rx #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .err_clr    (err_clr)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input int n);
    rxd = b;
    tick(n);
  endtask

  // Start bit, data bits and optional parity bit; stop left to caller.
  task automatic send_head(input logic [7:0] d,
                           input bit bad_par);
    drive(1'b0, C);
    for (int i = 0; i < 8; i++) drive(d[i], C);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ bad_par, C);
`else
    if (bad_par) drive(1'b1, 0);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d, 1'b0);
    drive(1'b1, C + 4);
  endtask

  task automatic drain;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun_err, 0);
    rst_n = 1'b1;
    tick(4);

    // Stop sample lands 154+16*PB edges after the start edge.
    send_head(8'hA5, 1'b0);
    drive(1'b1, 10);
    chk("a5_early", rx_valid, 0);
    drive(1'b1, 1);
    chk("a5_valid", rx_valid, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_ferr", fe_cnt, 0);
    chk("a5_ovr", overrun_err, 0);
    drive(1'b1, 9);
    drain();
    chk("a5_drain", rx_valid, 0);

    drive(1'b0, 4);
    drive(1'b1, 40);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_ferr", fe_cnt, 0);

    send_head(8'h3C, 1'b0);
    drive(1'b0, 40);
    drive(1'b1, 20);
    chk("brk_ferr", fe_cnt, 1);
    chk("brk_valid", rx_valid, 0);
    send_frame(8'h55);
    chk("55_valid", rx_valid, 1);
    chk("55_data", rx_data, 8'h55);
    chk("55_ferr", fe_cnt, 1);
    drain();

    send_frame(8'h11);
    send_frame(8'h22);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_set", overrun_err, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("ovr_clr", overrun_err, 0);
    chk("ovr_keep", rx_data, 8'h11);
    drain();
    chk("ovr_drain", rx_valid, 0);

    send_frame(8'h11);
    send_head(8'h22, 1'b0);
    drive(1'b1, 10);
    rx_ready = 1'b1;
    drive(1'b1, 1);
    rx_ready = 1'b0;
    chk("same_valid", rx_valid, 1);
    chk("same_data", rx_data, 8'h22);
    chk("same_ovr", overrun_err, 0);
    drive(1'b1, 9);
    send_frame(8'h33);
    chk("pre_rst_ovr", overrun_err, 1);

    drive(1'b0, C);
    drive(1'b1, 3 * C + 8);
    rst_n = 1'b0;
    tick(2);
    chk("mid_valid", rx_valid, 0);
    chk("mid_data", rx_data, 0);
    chk("mid_ovr", overrun_err, 0);
    chk("mid_ferr", frame_err, 0);
    rst_n = 1'b1;
    drive(1'b1, 8 + 4 * C + PB * C + C + 10);
    chk("mid_none", rx_valid, 0);
    send_frame(8'hF0);
    chk("f0_valid", rx_valid, 1);
    chk("f0_data", rx_data, 8'hF0);
    chk("f0_ferr", fe_cnt, 1);
    chk("f0_ovr", overrun_err, 0);
    drain();

`ifdef UART_RX_PARITY_EN
    chk("par_none", pe_cnt, 0);
    send_head(8'h07, 1'b1);
    drive(1'b1, C + 4);
    chk("par_err", pe_cnt, 1);
    chk("par_data", rx_data, 8'h07);
    chk("par_valid", rx_valid, 1);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
